// File: rtl/debug_wb_checker.sv
// In-order checker for the CPU debug writeback trace. Each retirement is compared
// against a loadable table of expected retirements. The checker reports pass/fail,
// an error count and the details of the first failure.
module debug_wb_checker #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 64,
  parameter int IDX_W       = $clog2(DEPTH),
  parameter int TIMEOUT     = 1024,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input  logic              fpga_clk,
  input  logic              fpga_rst,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_addr,
  input  logic [1:0]        exp_kind,
  input  logic [XLEN-1:0]   exp_pc,
  input  logic [4:0]        exp_reg,
  input  logic [XLEN-1:0]   exp_val,
  input  logic              start,
  input  logic [IDX_W:0]    num_entries,
  input  logic              debug_wb_have_inst,
  input  logic [XLEN-1:0]   debug_wb_pc,
  input  logic              debug_wb_ena,
  input  logic [4:0]        debug_wb_reg,
  input  logic [XLEN-1:0]   debug_wb_value,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [IDX_W:0]    pass_count,
  output logic [IDX_W-1:0]  fail_idx,
  output logic [XLEN-1:0]   fail_pc,
  output logic [2:0]        fail_code
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_e;
  typedef enum logic [1:0] {K_CHECK = 2'd0, K_NOWB = 2'd1, K_PCONLY = 2'd2, K_RSVD = 2'd3} kind_e;

  typedef struct packed {
    kind_e            kind;
    logic [XLEN-1:0]  pc;
    logic [4:0]       rd;
    logic [XLEN-1:0]  val;
  } entry_t;

  localparam logic [2:0] C_NONE  = 3'd0;
  localparam logic [2:0] C_PC    = 3'd1;
  localparam logic [2:0] C_MISS  = 3'd2;
  localparam logic [2:0] C_REG   = 3'd3;
  localparam logic [2:0] C_VAL   = 3'd4;
  localparam logic [2:0] C_UNEXP = 3'd5;
  localparam logic [2:0] C_TMO   = 3'd6;

  localparam logic [IDX_W:0] DEPTH_N  = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W:0] ONE_N    = (IDX_W + 1)'(1);
  localparam logic [31:0]    TMO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W:0]    n_q, n_d;
  logic [31:0]       tmo_q, tmo_d;
  logic [15:0]       err_q, err_d;
  logic [IDX_W:0]    pcnt_q, pcnt_d;
  logic [IDX_W-1:0]  fidx_q, fidx_d;
  logic [XLEN-1:0]   fpc_q, fpc_d;
  logic [2:0]        fcode_q, fcode_d;

  entry_t            table_q [DEPTH];
  entry_t            cur;
  logic [2:0]        cmp_code;
  logic              is_last;
  logic [15:0]       err_inc;

  // NOTE: the table is deliberately left out of reset so a loaded trace survives a reset.
  always_ff @(posedge fpga_clk) begin
    if (exp_we && state_q != S_RUN) begin
      table_q[exp_addr] <= '{kind: kind_e'(exp_kind), pc: exp_pc, rd: exp_reg, val: exp_val};
    end
  end

  assign cur     = table_q[idx_q];
  assign is_last = (({1'b0, idx_q} + ONE_N) == n_q);
  assign err_inc = (err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;

  // First failing condition wins; PCONLY and the reserved kind check the PC only.
  always_comb begin
    cmp_code = C_NONE;
    if (debug_wb_pc != cur.pc) begin
      cmp_code = C_PC;
    end else if (cur.kind == K_CHECK) begin
      if (!debug_wb_ena)                cmp_code = C_MISS;
      else if (debug_wb_reg != cur.rd)  cmp_code = C_REG;
      else if (debug_wb_value != cur.val) cmp_code = C_VAL;
    end else if (cur.kind == K_NOWB && debug_wb_ena) begin
      cmp_code = C_UNEXP;
    end
  end

  // NOTE: every _d is defaulted to its register first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    pcnt_d  = pcnt_q;
    fidx_d  = fidx_q;
    fpc_d   = fpc_q;
    fcode_d = fcode_q;
    case (state_q)
      S_RUN: begin
        if (debug_wb_have_inst) begin
          tmo_d = 32'd0;
          if (cmp_code == C_NONE) begin
            pcnt_d = pcnt_q + ONE_N;
          end else begin
            err_d = err_inc;
            if (fcode_q == C_NONE) begin
              fidx_d  = idx_q;
              fpc_d   = debug_wb_pc;
              fcode_d = cmp_code;
            end
          end
          if (cmp_code != C_NONE && STOP_ON_ERR) begin
            state_d = S_FAIL;
          end else if (is_last) begin
            state_d = (err_q == 16'd0 && cmp_code == C_NONE) ? S_PASS : S_FAIL;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (TIMEOUT > 0 && tmo_q == TMO_LAST) begin
          state_d = S_FAIL;
          if (fcode_q == C_NONE) begin
            fidx_d  = idx_q;
            fpc_d   = cur.pc;
            fcode_d = C_TMO;
          end
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      default: begin
        if (start) begin
          idx_d   = '0;
          tmo_d   = 32'd0;
          err_d   = 16'd0;
          pcnt_d  = '0;
          fidx_d  = '0;
          fpc_d   = '0;
          fcode_d = C_NONE;
          n_d     = (num_entries > DEPTH_N) ? DEPTH_N : num_entries;
          state_d = (num_entries == '0) ? S_PASS : S_RUN;
        end
      end
    endcase
  end

  // NOTE: registers take their next state with <= so all of them update together at the edge.
  always_ff @(posedge fpga_clk) begin
    if (!fpga_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      tmo_q   <= 32'd0;
      err_q   <= 16'd0;
      pcnt_q  <= '0;
      fidx_q  <= '0;
      fpc_q   <= '0;
      fcode_q <= C_NONE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      pcnt_q  <= pcnt_d;
      fidx_q  <= fidx_d;
      fpc_q   <= fpc_d;
      fcode_q <= fcode_d;
    end
  end

  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_PASS) || (state_q == S_FAIL);
  assign pass       = (state_q == S_PASS);
  assign err_count  = err_q;
  assign pass_count = pcnt_q;
  assign fail_idx   = fidx_q;
  assign fail_pc    = fpc_q;
  assign fail_code  = fcode_q;

endmodule

// File: tb/tb_debug_wb_checker.sv
// Scoreboard bench: two checkers (stop-on-error and continue) share one stimulus stream.
// Expected final results are queued before each run and popped whenever a checker reports done.
module tb_debug_wb_checker;

  logic        fpga_clk, fpga_rst;
  logic        exp_we;
  logic [5:0]  exp_addr;
  logic [1:0]  exp_kind;
  logic [31:0] exp_pc, exp_val;
  logic [4:0]  exp_reg;
  logic        start;
  logic [6:0]  num_entries;
  logic        have_inst, wb_ena;
  logic [31:0] wb_pc, wb_value;
  logic [4:0]  wb_reg;

  logic        s_busy, s_done, s_pass, c_busy, c_done, c_pass;
  logic [15:0] s_err, c_err;
  logic [6:0]  s_pcnt, c_pcnt;
  logic [5:0]  s_fidx, c_fidx;
  logic [31:0] s_fpc, c_fpc;
  logic [2:0]  s_code, c_code;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        pass;
    logic [15:0] err;
    logic [6:0]  pcnt;
    logic [5:0]  fidx;
    logic [31:0] fpc;
    logic [2:0]  code;
  } exp_t;

  exp_t q_s[$];
  exp_t q_c[$];

  debug_wb_checker #(.TIMEOUT(16), .STOP_ON_ERR(1'b1)) dut_s (
    .fpga_clk(fpga_clk), .fpga_rst(fpga_rst), .exp_we(exp_we), .exp_addr(exp_addr),
    .exp_kind(exp_kind), .exp_pc(exp_pc), .exp_reg(exp_reg), .exp_val(exp_val),
    .start(start), .num_entries(num_entries), .debug_wb_have_inst(have_inst),
    .debug_wb_pc(wb_pc), .debug_wb_ena(wb_ena), .debug_wb_reg(wb_reg),
    .debug_wb_value(wb_value), .busy(s_busy), .done(s_done), .pass(s_pass),
    .err_count(s_err), .pass_count(s_pcnt), .fail_idx(s_fidx), .fail_pc(s_fpc),
    .fail_code(s_code));

  debug_wb_checker #(.TIMEOUT(16), .STOP_ON_ERR(1'b0)) dut_c (
    .fpga_clk(fpga_clk), .fpga_rst(fpga_rst), .exp_we(exp_we), .exp_addr(exp_addr),
    .exp_kind(exp_kind), .exp_pc(exp_pc), .exp_reg(exp_reg), .exp_val(exp_val),
    .start(start), .num_entries(num_entries), .debug_wb_have_inst(have_inst),
    .debug_wb_pc(wb_pc), .debug_wb_ena(wb_ena), .debug_wb_reg(wb_reg),
    .debug_wb_value(wb_value), .busy(c_busy), .done(c_done), .pass(c_pass),
    .err_count(c_err), .pass_count(c_pcnt), .fail_idx(c_fidx), .fail_pc(c_fpc),
    .fail_code(c_code));

  initial fpga_clk = 1'b0;
  always #5 fpga_clk = ~fpga_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic pass_a, input logic [15:0] err_a,
                     input logic [6:0] pcnt_a, input logic [5:0] fidx_a, input logic [31:0] fpc_a,
                     input logic [2:0] code_a);
    check({tag, ":", e.name, ".pass"},       pass_a, e.pass);
    check({tag, ":", e.name, ".err_count"},  err_a,  e.err);
    check({tag, ":", e.name, ".pass_count"}, pcnt_a, e.pcnt);
    check({tag, ":", e.name, ".fail_idx"},   fidx_a, e.fidx);
    check({tag, ":", e.name, ".fail_pc"},    fpc_a,  e.fpc);
    check({tag, ":", e.name, ".fail_code"},  code_a, e.code);
  endtask

  // Monitors: a rising done is the checker presenting a result.
  logic s_prev = 1'b0, c_prev = 1'b0;
  always @(negedge fpga_clk) begin
    if (s_done && !s_prev) begin
      checks++;
      if (q_s.size() == 0) begin
        errors++;
        $display("FAIL stop_dut: done with no expected result queued");
      end else begin
        cmp("stop_dut", q_s.pop_front(), s_pass, s_err, s_pcnt, s_fidx, s_fpc, s_code);
      end
    end
    s_prev = s_done;
  end

  always @(negedge fpga_clk) begin
    if (c_done && !c_prev) begin
      checks++;
      if (q_c.size() == 0) begin
        errors++;
        $display("FAIL cont_dut: done with no expected result queued");
      end else begin
        cmp("cont_dut", q_c.pop_front(), c_pass, c_err, c_pcnt, c_fidx, c_fpc, c_code);
      end
    end
    c_prev = c_done;
  end

  task automatic tick();
    @(posedge fpga_clk);
    #1;
  endtask

  task automatic load(input logic [5:0] a, input logic [1:0] k, input logic [31:0] pc,
                      input logic [4:0] rd, input logic [31:0] v);
    exp_we = 1'b1; exp_addr = a; exp_kind = k; exp_pc = pc; exp_reg = rd; exp_val = v;
    tick();
    exp_we = 1'b0;
  endtask

  task automatic start_run(input logic [6:0] n);
    start = 1'b1; num_entries = n;
    tick();
    start = 1'b0;
  endtask

  task automatic retire(input logic [31:0] pc, input logic ena, input logic [4:0] rd, input logic [31:0] v);
    have_inst = 1'b1; wb_pc = pc; wb_ena = ena; wb_reg = rd; wb_value = v;
    tick();
    have_inst = 1'b0; wb_ena = 1'b0;
  endtask

  task automatic t1_trace();
    retire(32'h00, 1'b1, 5'd1, 32'd10);
    retire(32'h04, 1'b1, 5'd2, 32'hFFFF_FFFB);
    retire(32'h08, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic wait_both(input string tag);
    for (int i = 0; i < 64 && !(s_done && c_done); i++) tick();
    check({tag, ".done_within_budget"}, {s_done, c_done}, 2'b11);
    tick();
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"}, {s_busy, c_busy}, 2'b00);
    check({tag, ".done"}, {s_done, c_done}, 2'b00);
    check({tag, ".pass"}, {s_pass, c_pass}, 2'b00);
    check({tag, ".err_count"},  {s_err, c_err},   32'd0);
    check({tag, ".pass_count"}, {s_pcnt, c_pcnt}, 14'd0);
    check({tag, ".fail_idx"},   {s_fidx, c_fidx}, 12'd0);
    check({tag, ".fail_pc"},    {s_fpc, c_fpc},   64'd0);
    check({tag, ".fail_code"},  {s_code, c_code}, 6'd0);
  endtask

  function automatic exp_t mk(input string n, input logic p, input logic [15:0] e, input logic [6:0] pc_n,
                              input logic [5:0] fi, input logic [31:0] fp, input logic [2:0] code);
    exp_t r;
    r.name = n; r.pass = p; r.err = e; r.pcnt = pc_n; r.fidx = fi; r.fpc = fp; r.code = code;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    fpga_rst = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_kind = '0; exp_pc = '0; exp_reg = '0;
    exp_val = '0; start = 1'b0; num_entries = '0; have_inst = 1'b0; wb_pc = '0; wb_ena = 1'b0;
    wb_reg = '0; wb_value = '0;
    tick(); tick();
    check_idle("reset_init");
    fpga_rst = 1'b1;
    tick();

    // T1: matching trace
    load(6'd0, 2'd0, 32'h00, 5'd1, 32'd10);
    load(6'd1, 2'd0, 32'h04, 5'd2, 32'hFFFF_FFFB);
    load(6'd2, 2'd1, 32'h08, 5'd0, 32'd0);
    q_s.push_back(mk("t1", 1'b1, 16'd0, 7'd3, 6'd0, 32'h0, 3'd0));
    q_c.push_back(mk("t1", 1'b1, 16'd0, 7'd3, 6'd0, 32'h0, 3'd0));
    start_run(7'd3);
    t1_trace();
    wait_both("t1");

    // T2: table idx1 expects 0xFFFFFFFA, trace delivers 0xFFFFFFFB
    load(6'd1, 2'd0, 32'h04, 5'd2, 32'hFFFF_FFFA);
    q_s.push_back(mk("t2", 1'b0, 16'd1, 7'd1, 6'd1, 32'h04, 3'd4));
    q_c.push_back(mk("t2", 1'b0, 16'd1, 7'd2, 6'd1, 32'h04, 3'd4));
    start_run(7'd3);
    retire(32'h00, 1'b1, 5'd1, 32'd10);
    retire(32'h04, 1'b1, 5'd2, 32'hFFFF_FFFB);
    check("t2.fail_one_cycle_after_retire", {s_done, s_pass}, 2'b10);
    retire(32'h08, 1'b0, 5'd0, 32'd0);
    retire(32'h0C, 1'b1, 5'd7, 32'd1);
    wait_both("t2");
    check("t2.later_retirements_ignored.err", s_err, 16'd1);
    check("t2.later_retirements_ignored.pcnt", s_pcnt, 7'd1);

    // T3: unexpected writeback on the NOWB entry
    load(6'd1, 2'd0, 32'h04, 5'd2, 32'hFFFF_FFFB);
    q_s.push_back(mk("t3", 1'b0, 16'd1, 7'd2, 6'd2, 32'h08, 3'd5));
    q_c.push_back(mk("t3", 1'b0, 16'd1, 7'd2, 6'd2, 32'h08, 3'd5));
    start_run(7'd3);
    retire(32'h00, 1'b1, 5'd1, 32'd10);
    retire(32'h04, 1'b1, 5'd2, 32'hFFFF_FFFB);
    retire(32'h08, 1'b1, 5'd3, 32'd5);
    wait_both("t3");

    // T4: timeout, 16 cycles after the start edge
    q_s.push_back(mk("t4", 1'b0, 16'd0, 7'd0, 6'd0, 32'h00, 3'd6));
    q_c.push_back(mk("t4", 1'b0, 16'd0, 7'd0, 6'd0, 32'h00, 3'd6));
    start_run(7'd3);
    repeat (15) tick();
    check("t4.still_running_at_15", {s_busy, c_busy, s_done, c_done}, 4'b1100);
    tick();
    check("t4.failed_at_16", {s_done, c_done, s_pass, c_pass}, 4'b1100);
    wait_both("t4");

    // T6a: PC and value both wrong -> PC mismatch wins
    q_s.push_back(mk("t6_prio", 1'b0, 16'd1, 7'd0, 6'd0, 32'h40, 3'd1));
    q_c.push_back(mk("t6_prio", 1'b0, 16'd1, 7'd0, 6'd0, 32'h40, 3'd1));
    start_run(7'd1);
    retire(32'h40, 1'b1, 5'd1, 32'd99);
    wait_both("t6_prio");

    // T6b: a table write during RUN must not take effect
    q_s.push_back(mk("t6_lock", 1'b1, 16'd0, 7'd3, 6'd0, 32'h0, 3'd0));
    q_c.push_back(mk("t6_lock", 1'b1, 16'd0, 7'd3, 6'd0, 32'h0, 3'd0));
    start_run(7'd3);
    retire(32'h00, 1'b1, 5'd1, 32'd10);
    load(6'd1, 2'd0, 32'h04, 5'd2, 32'h0000_1234);
    retire(32'h04, 1'b1, 5'd2, 32'hFFFF_FFFB);
    retire(32'h08, 1'b0, 5'd0, 32'd0);
    wait_both("t6_lock");

    // T5: reset mid-run at idx 2, then restart on the retained table
    start_run(7'd3);
    retire(32'h00, 1'b1, 5'd1, 32'd10);
    retire(32'h04, 1'b1, 5'd2, 32'hFFFF_FFFB);
    fpga_rst = 1'b0;
    tick();
    check_idle("t5_reset");
    fpga_rst = 1'b1;
    q_s.push_back(mk("n0", 1'b1, 16'd0, 7'd0, 6'd0, 32'h0, 3'd0));
    q_c.push_back(mk("n0", 1'b1, 16'd0, 7'd0, 6'd0, 32'h0, 3'd0));
    start_run(7'd0);
    check("n0.pass_immediately", {s_pass, c_pass}, 2'b11);
    tick();
    q_s.push_back(mk("t5_rerun", 1'b1, 16'd0, 7'd3, 6'd0, 32'h0, 3'd0));
    q_c.push_back(mk("t5_rerun", 1'b1, 16'd0, 7'd3, 6'd0, 32'h0, 3'd0));
    start_run(7'd3);
    t1_trace();
    wait_both("t5_rerun");

    check("scoreboard_drained_stop", q_s.size(), 0);
    check("scoreboard_drained_cont", q_c.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
